// File: rtl/projectile_pool_if.sv
// Projectile pool bus: groups the game-control request side and the
// per-slot position/alive outputs consumed by hit-test and colour mapping.
//   master : game control / testbench (drives requests, reads slot state)
//   slave  : projectile_pool
// Signals:
//   clear        synchronous flush of all slots
//   fire         fire request level
//   dir          00 +x, 01 -x, 10 -y, 11 +x and -y
//   origin_x/y   spawn coordinates
//   scroll       world scrolled this frame
//   hit_mask     per-slot kill from hit-test
//   pos_x/pos_y  flattened slot positions, slot i at [i*W +: W]
//   alive        slot valid mask
//   active_count popcount of alive
//   fire_ack     one-frame pulse: projectile spawned this frame
interface projectile_pool_if #(
   parameter int unsigned N_SLOTS = 5,
   parameter int unsigned X_W     = 10,
   parameter int unsigned Y_W     = 10
);

   logic                   clear;
   logic                   fire;
   logic [1:0]             dir;
   logic [X_W-1:0]         origin_x;
   logic [Y_W-1:0]         origin_y;
   logic                   scroll;
   logic [N_SLOTS-1:0]     hit_mask;
   logic [N_SLOTS*X_W-1:0] pos_x;
   logic [N_SLOTS*Y_W-1:0] pos_y;
   logic [N_SLOTS-1:0]     alive;
   logic [4:0]             active_count;
   logic                   fire_ack;

   modport master (
      output clear, fire, dir, origin_x, origin_y, scroll, hit_mask,
      input  pos_x, pos_y, alive, active_count, fire_ack
   );

   modport slave (
      input  clear, fire, dir, origin_x, origin_y, scroll, hit_mask,
      output pos_x, pos_y, alive, active_count, fire_ack
   );

endinterface

// File: rtl/projectile_pool.sv
// N-slot projectile manager. Once per frame it spawns a projectile into the
// lowest free slot on an accepted fire request, moves every live projectile
// by SPEED along its latched direction, applies world scroll, and retires
// projectiles that leave the screen or are hit.
// Ports:
//   frame_clk  frame clock (vertical sync), all state on rising edge
//   Reset_n    asynchronous active-low reset
//   bus        projectile_pool_if.slave (requests in, slot state out)
module projectile_pool #(
   parameter int unsigned N_SLOTS     = 5,
   parameter int unsigned X_W         = 10,
   parameter int unsigned Y_W         = 10,
   parameter int unsigned SPEED       = 8,
   parameter int unsigned COOLDOWN    = 6,
   parameter int unsigned SCROLL_STEP = 4,
   parameter int unsigned SCREEN_W    = 640,
   parameter int unsigned AUTO_FIRE   = 0
) (
   input  logic              frame_clk,
   input  logic              Reset_n,
   projectile_pool_if.slave  bus
);

   localparam int unsigned CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam int unsigned IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int unsigned CNT_W = 5;
   // Two extra bits: one for sign, one of headroom so a spawn near the top
   // of the coordinate range cannot wrap when it moves forward.
   localparam int unsigned SX_W  = X_W + 2;
   localparam int unsigned SY_W  = Y_W + 2;

   localparam logic signed [SX_W-1:0] SPEED_X  = SX_W'(SPEED);
   localparam logic signed [SY_W-1:0] SPEED_Y  = SY_W'(SPEED);
   localparam logic signed [SX_W-1:0] SCROLL_X = SX_W'(SCROLL_STEP);
   localparam logic signed [SX_W-1:0] SCREEN_X = SX_W'(SCREEN_W);
   localparam logic [CD_W-1:0]        CD_LOAD  = CD_W'(COOLDOWN);

   // Registered state
   logic [N_SLOTS-1:0] alive_q;
   logic [X_W-1:0]     x_q   [N_SLOTS];
   logic [Y_W-1:0]     y_q   [N_SLOTS];
   logic [1:0]         dir_q [N_SLOTS];
   logic [CD_W-1:0]    cd_q;
   logic               fire_prev_q;
   logic               fire_ack_q;
   logic [CNT_W-1:0]   count_q;

   // Next-state values
   logic [N_SLOTS-1:0] alive_d;
   logic [X_W-1:0]     x_d   [N_SLOTS];
   logic [Y_W-1:0]     y_d   [N_SLOTS];
   logic [1:0]         dir_d [N_SLOTS];
   logic [CD_W-1:0]    cd_d;
   logic               fire_ack_d;
   logic [CNT_W-1:0]   count_d;

   // Per-frame decisions
   logic               fire_req;
   logic               free_found;
   logic [IDX_W-1:0]   free_idx;
   logic               accept;
   logic signed [SX_W-1:0] nx [N_SLOTS];
   logic signed [SY_W-1:0] ny [N_SLOTS];
   logic [N_SLOTS-1:0] retire;

   // Edge-detected request in single-shot mode, level in auto-fire mode
   always_comb begin
      fire_req = (AUTO_FIRE != 0) ? bus.fire : (bus.fire & ~fire_prev_q);
   end

   // Lowest-index free slot, judged on the alive mask before this frame's update
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (!alive_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Candidate motion for every slot in widened signed arithmetic
   always_comb begin
      for (int i = 0; i < N_SLOTS; i++) begin
         nx[i] = $signed({2'b00, x_q[i]});
         ny[i] = $signed({2'b00, y_q[i]});
         case (dir_q[i])
            2'b00: nx[i] = nx[i] + SPEED_X;
            2'b01: nx[i] = nx[i] - SPEED_X;
            2'b10: ny[i] = ny[i] - SPEED_Y;
            2'b11: begin
               nx[i] = nx[i] + SPEED_X;
               ny[i] = ny[i] - SPEED_Y;
            end
         endcase
         if (bus.scroll) begin
            nx[i] = nx[i] - SCROLL_X;
         end
         retire[i] = nx[i][SX_W-1] || (nx[i] >= SCREEN_X) || ny[i][SY_W-1];
      end
   end

   // Frame update: kill/move existing slots, then spawn, then clear override
   always_comb begin
      alive_d    = alive_q;
      x_d        = x_q;
      y_d        = y_q;
      dir_d      = dir_q;
      cd_d       = cd_q;
      fire_ack_d = 1'b0;
      count_d    = '0;

      accept = fire_req & (cd_q == '0) & free_found;

      // Hit or retire both kill; a killed slot keeps its last position
      for (int i = 0; i < N_SLOTS; i++) begin
         if (alive_q[i]) begin
            if (bus.hit_mask[i] || retire[i]) begin
               alive_d[i] = 1'b0;
            end else begin
               x_d[i] = nx[i][X_W-1:0];
               y_d[i] = ny[i][Y_W-1:0];
            end
         end
      end

      // Free slot was dead before the update, so the loop above never touched it
      if (accept) begin
         alive_d[free_idx] = 1'b1;
         x_d[free_idx]     = bus.origin_x;
         y_d[free_idx]     = bus.origin_y;
         dir_d[free_idx]   = bus.dir;
         cd_d              = CD_LOAD;
         fire_ack_d        = 1'b1;
      end else if (cd_q != '0) begin
         cd_d = cd_q - CD_W'(1);
      end

      if (bus.clear) begin
         alive_d    = '0;
         cd_d       = '0;
         fire_ack_d = 1'b0;
         for (int i = 0; i < N_SLOTS; i++) begin
            x_d[i]   = '0;
            y_d[i]   = '0;
            dir_d[i] = '0;
         end
      end

      for (int i = 0; i < N_SLOTS; i++) begin
         count_d = count_d + CNT_W'(alive_d[i]);
      end
   end

   // State registers
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         alive_q     <= '0;
         cd_q        <= '0;
         fire_prev_q <= 1'b0;
         fire_ack_q  <= 1'b0;
         count_q     <= '0;
         for (int i = 0; i < N_SLOTS; i++) begin
            x_q[i]   <= '0;
            y_q[i]   <= '0;
            dir_q[i] <= '0;
         end
      end else begin
         alive_q     <= alive_d;
         cd_q        <= cd_d;
         fire_prev_q <= bus.fire;
         fire_ack_q  <= fire_ack_d;
         count_q     <= count_d;
         for (int i = 0; i < N_SLOTS; i++) begin
            x_q[i]   <= x_d[i];
            y_q[i]   <= y_d[i];
            dir_q[i] <= dir_d[i];
         end
      end
   end

   // Flatten slot registers onto the output buses
   logic [N_SLOTS*X_W-1:0] pos_x_flat;
   logic [N_SLOTS*Y_W-1:0] pos_y_flat;

   always_comb begin
      pos_x_flat = '0;
      pos_y_flat = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         pos_x_flat[i*X_W +: X_W] = x_q[i];
         pos_y_flat[i*Y_W +: Y_W] = y_q[i];
      end
   end

   assign bus.pos_x        = pos_x_flat;
   assign bus.pos_y        = pos_y_flat;
   assign bus.alive        = alive_q;
   assign bus.active_count = count_q;
   assign bus.fire_ack     = fire_ack_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Testbench for projectile_pool: two instances (single-shot and auto-fire)
// share one stimulus stream; a slot-level reference model predicts every
// output each frame, with directed scenarios followed by random frames.
module tb_projectile_pool;

   localparam int N        = 5;
   localparam int SPEED    = 8;
   localparam int COOLDOWN = 6;
   localparam int SCROLL   = 4;
   localparam int SCREEN   = 640;

   logic       frame_clk = 1'b0;
   logic       Reset_n;
   logic       clear, fire, scroll;
   logic [1:0] dir;
   logic [9:0] ox, oy;
   logic [4:0] hit;

   int vectors = 0;
   int errs    = 0;
   int n0, n1;

   // Reference model state, index [instance][slot]
   int m_alive [2][N];
   int m_x     [2][N];
   int m_y     [2][N];
   int m_dir   [2][N];
   int m_cd    [2];
   int m_prev  [2];
   int m_ack   [2];

   always #5 frame_clk = ~frame_clk;

   projectile_pool_if #(.N_SLOTS(5), .X_W(10), .Y_W(10)) bus0 ();
   projectile_pool_if #(.N_SLOTS(5), .X_W(10), .Y_W(10)) bus1 ();

   assign bus0.clear = clear;    assign bus1.clear = clear;
   assign bus0.fire = fire;      assign bus1.fire = fire;
   assign bus0.dir = dir;        assign bus1.dir = dir;
   assign bus0.origin_x = ox;    assign bus1.origin_x = ox;
   assign bus0.origin_y = oy;    assign bus1.origin_y = oy;
   assign bus0.scroll = scroll;  assign bus1.scroll = scroll;
   assign bus0.hit_mask = hit;   assign bus1.hit_mask = hit;

   projectile_pool #(.AUTO_FIRE(0)) dut0 (
      .frame_clk(frame_clk), .Reset_n(Reset_n), .bus(bus0)
   );
   projectile_pool #(.AUTO_FIRE(1)) dut1 (
      .frame_clk(frame_clk), .Reset_n(Reset_n), .bus(bus1)
   );

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < N; i++) begin
            m_alive[k][i] = 0; m_x[k][i] = 0; m_y[k][i] = 0; m_dir[k][i] = 0;
         end
         m_cd[k] = 0; m_prev[k] = 0; m_ack[k] = 0;
      end
   endfunction

   // One frame of game rules for instance k (k==1 is auto-fire)
   function automatic void model_step(int k);
      int  free;
      int  nx, ny;
      bit  req;
      if (clear) begin
         for (int i = 0; i < N; i++) begin
            m_alive[k][i] = 0; m_x[k][i] = 0; m_y[k][i] = 0;
         end
         m_cd[k] = 0; m_ack[k] = 0; m_prev[k] = int'(fire);
         return;
      end
      req = (k == 1) ? fire : (fire && (m_prev[k] == 0));
      m_prev[k] = int'(fire);
      free = -1;
      for (int i = N - 1; i >= 0; i--) if (m_alive[k][i] == 0) free = i;
      for (int i = 0; i < N; i++) begin
         if (m_alive[k][i] != 0) begin
            if (hit[i]) m_alive[k][i] = 0;
            else begin
               nx = m_x[k][i]; ny = m_y[k][i];
               if (m_dir[k][i] == 0 || m_dir[k][i] == 3) nx += SPEED;
               if (m_dir[k][i] == 1) nx -= SPEED;
               if (m_dir[k][i] == 2 || m_dir[k][i] == 3) ny -= SPEED;
               if (scroll) nx -= SCROLL;
               if (nx < 0 || nx >= SCREEN || ny < 0) m_alive[k][i] = 0;
               else begin m_x[k][i] = nx; m_y[k][i] = ny; end
            end
         end
      end
      if (req && m_cd[k] == 0 && free >= 0) begin
         m_alive[k][free] = 1; m_x[k][free] = int'(ox); m_y[k][free] = int'(oy);
         m_dir[k][free] = int'(dir); m_cd[k] = COOLDOWN; m_ack[k] = 1;
      end else begin
         m_ack[k] = 0;
         if (m_cd[k] > 0) m_cd[k]--;
      end
   endfunction

   task automatic check_inst(int k, logic [4:0] a, logic [49:0] px, logic [49:0] py,
                             logic [4:0] c, logic ack);
      logic [4:0]  ea, ec;
      logic [49:0] ex, ey;
      logic        eack;
      int          cnt;
      ea = '0; ex = '0; ey = '0; cnt = 0;
      for (int i = 0; i < N; i++) begin
         ea[i] = (m_alive[k][i] != 0);
         ex[i*10 +: 10] = 10'(m_x[k][i]);
         ey[i*10 +: 10] = 10'(m_y[k][i]);
         cnt += m_alive[k][i];
      end
      ec = 5'(cnt);
      eack = (m_ack[k] != 0);
      vectors++;
      assert (a === ea) else begin errs++; $error("FAIL alive_%0d observed=%b expected=%b", k, a, ea); end
      vectors++;
      assert (px === ex) else begin errs++; $error("FAIL pos_x_%0d observed=%h expected=%h", k, px, ex); end
      vectors++;
      assert (py === ey) else begin errs++; $error("FAIL pos_y_%0d observed=%h expected=%h", k, py, ey); end
      vectors++;
      assert (c === ec) else begin errs++; $error("FAIL count_%0d observed=%0d expected=%0d", k, c, ec); end
      vectors++;
      assert (ack === eack) else begin errs++; $error("FAIL ack_%0d observed=%b expected=%b", k, ack, eack); end
   endtask

   task automatic check_all();
      check_inst(0, bus0.alive, bus0.pos_x, bus0.pos_y, bus0.active_count, bus0.fire_ack);
      check_inst(1, bus1.alive, bus1.pos_x, bus1.pos_y, bus1.active_count, bus1.fire_ack);
   endtask

   task automatic chk(string tag, int obs, int exp);
      vectors++;
      assert (obs === exp) else begin errs++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); end
   endtask

   // Model consumes current inputs, DUT takes the edge, outputs sampled 1 ns later
   task automatic step();
      model_step(0);
      model_step(1);
      @(posedge frame_clk);
      #1;
      check_all();
   endtask

   task automatic retire_case(string tag, int x0, int y0, int d, bit sc);
      fire = 1'b1; ox = 10'(x0); oy = 10'(y0); dir = 2'(d);
      step();
      fire = 1'b0; scroll = sc;
      step();
      chk({tag, "_0"}, int'(bus0.alive[0]), 0);
      chk({tag, "_1"}, int'(bus1.alive[0]), 0);
      scroll = 1'b0;
      repeat (5) step();
   endtask

   task automatic randomize_inputs();
      fire   = ($urandom_range(0, 2) != 0);
      dir    = 2'($urandom_range(0, 3));
      ox     = 10'($urandom_range(0, 1023));
      oy     = 10'($urandom_range(0, 1023));
      scroll = ($urandom_range(0, 3) == 0);
      hit    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      clear  = ($urandom_range(0, 49) == 0);
   endtask

   initial begin
      Reset_n = 1'b0;
      clear = 1'b0; fire = 1'b0; scroll = 1'b0; dir = 2'b00;
      ox = '0; oy = '0; hit = '0;
      model_reset();
      #12;
      check_all();
      Reset_n = 1'b1;

      // First shot and first motion, fire then held for 20 frames total
      fire = 1'b1; ox = 10'd100; oy = 10'd200; dir = 2'b00;
      step();
      chk("spawn_ack", int'(bus0.fire_ack), 1);
      chk("spawn_alive", int'(bus0.alive), 1);
      chk("spawn_x", int'(bus0.pos_x[9:0]), 100);
      chk("spawn_y", int'(bus0.pos_y[9:0]), 200);
      n0 = int'(bus0.fire_ack); n1 = int'(bus1.fire_ack);
      step();
      chk("move_x", int'(bus0.pos_x[9:0]), 108);
      chk("move_count", int'(bus0.active_count), 1);
      n0 += int'(bus0.fire_ack); n1 += int'(bus1.fire_ack);
      repeat (18) begin
         step();
         n0 += int'(bus0.fire_ack); n1 += int'(bus1.fire_ack);
      end
      chk("held_single", n0, 1);
      chk("held_auto", n1, 3);
      chk("auto_alive", int'(bus1.alive), 7);

      fire = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;

      // Fill every slot, then a request with the pool full
      ox = 10'd300; oy = 10'd460; dir = 2'b10;
      repeat (5) begin
         fire = 1'b1; step();
         fire = 1'b0; repeat (6) step();
      end
      chk("fill_alive", int'(bus0.alive), 31);
      fire = 1'b1;
      step();
      chk("full_ack", int'(bus0.fire_ack), 0);
      chk("full_alive", int'(bus0.alive), 31);
      fire = 1'b0; hit = 5'b00100;
      step();
      chk("hit_alive", int'(bus0.alive), 27);
      hit = '0; fire = 1'b1;
      step();
      chk("refill_ack", int'(bus0.fire_ack), 1);
      chk("refill_alive", int'(bus0.alive), 31);
      chk("refill_x", int'(bus0.pos_x[29:20]), 300);
      fire = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;

      // Screen-edge retirement in each direction
      retire_case("ret_px", 636, 100, 0, 1'b0);
      retire_case("ret_nx", 5, 100, 1, 1'b0);
      retire_case("ret_ny", 100, 3, 3, 1'b0);
      retire_case("ret_scroll", 2, 100, 2, 1'b1);

      // Hit on a retiring slot in the same frame as a new accepted fire
      fire = 1'b1; ox = 10'd590; oy = 10'd100; dir = 2'b00;
      step();
      fire = 1'b0;
      repeat (6) step();
      chk("edge_alive", int'(bus0.alive), 1);
      fire = 1'b1; hit = 5'b00001; ox = 10'd50;
      step();
      chk("same_alive", int'(bus0.alive), 2);
      chk("same_x", int'(bus0.pos_x[19:10]), 50);
      fire = 1'b0; hit = '0; clear = 1'b1;
      step();
      clear = 1'b0;

      // Clear with three live projectiles and cooldown at 4
      ox = 10'd200; oy = 10'd300; dir = 2'b00;
      repeat (2) begin
         fire = 1'b1; step();
         fire = 1'b0; repeat (6) step();
      end
      fire = 1'b1; step();
      fire = 1'b0; repeat (2) step();
      chk("three_count", int'(bus0.active_count), 3);
      clear = 1'b1;
      step();
      chk("clear_alive", int'(bus0.alive), 0);
      chk("clear_count", int'(bus0.active_count), 0);
      clear = 1'b0; fire = 1'b1;
      step();
      chk("post_clear_ack0", int'(bus0.fire_ack), 1);
      chk("post_clear_ack1", int'(bus1.fire_ack), 1);

      // Random frames
      for (int f = 0; f < 400; f++) begin
         randomize_inputs();
         step();
      end

      // Reset mid-flight, between edges
      clear = 1'b0; fire = 1'b0; hit = '0; scroll = 1'b0;
      fire = 1'b1; step();
      Reset_n = 1'b0;
      #2;
      model_reset();
      check_all();
      chk("rst_alive0", int'(bus0.alive), 0);
      chk("rst_ack0", int'(bus0.fire_ack), 0);
      Reset_n = 1'b1;
      fire = 1'b0;
      for (int f = 0; f < 100; f++) begin
         randomize_inputs();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
